// File: rtl/load_store_unit.sv
// load_store_unit: registered load/store stage with req/gnt/rvalid memory handshake; define MISALIGN_TRAP_EN to trap misaligned accesses
module load_store_unit #(
  parameter int XLEN = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              is_store_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [XLEN-1:0]   rs1_i,
  input  logic [XLEN-1:0]   rs2_i,
  input  logic [XLEN-1:0]   imm_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [XLEN-1:0]   dmem_addr_o,
  output logic [XLEN/8-1:0] dmem_be_o,
  output logic [XLEN-1:0]   dmem_wdata_o,
  input  logic              dmem_gnt_i,
  input  logic              dmem_rvalid_i,
  input  logic [XLEN-1:0]   dmem_rdata_i,
  output logic              done_o,
  output logic [XLEN-1:0]   load_data_o,
  output logic              err_o,
  output logic [1:0]        err_cause_o,
  output logic              busy_o
);
  localparam int NB = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3;
  logic [1:0] state, cause, err_next, size_q;
  logic store_q, uns_q, illegal;
  logic [OFFW-1:0] off_raw, mask, off, off_q;
  logic [XLEN-1:0] ea, shifted, lifted, ext, ld_q;
  logic [NB-1:0] be_n;
  logic [6:0] sa;
  logic [CW-1:0] cnt;
`ifdef MISALIGN_TRAP_EN
  logic misalign;
`endif
  // Request-side decode: effective address, lane offset, byte enables and error classification
  always_comb begin
    ea = rs1_i + imm_i;
    off_raw = ea[OFFW-1:0];
    mask = OFFW'((4'd1 << size_i) - 4'd1);
    illegal = (XLEN == 32) && (size_i == 2'd3);
`ifdef MISALIGN_TRAP_EN
    misalign = |(off_raw & mask);
    off = off_raw;
    err_next = illegal ? 2'd2 : misalign ? 2'd1 : 2'd0;
`else
    off = off_raw & ~mask;
    err_next = illegal ? 2'd2 : 2'd0;
`endif
    be_n = ~({NB{1'b1}} << (5'd1 << size_i)) << off;
  end
  // Load-side extraction: move the addressed lane to bit 0, then truncate and extend via a shift pair
  always_comb begin
    shifted = dmem_rdata_i >> {off_q, 3'b000};
    sa = 7'(XLEN) - (7'd8 << size_q);
    lifted = shifted << sa;
    ext = uns_q ? lifted >> sa : $unsigned($signed(lifted) >>> sa);
  end
  // Access FSM; the memory-side fields are captured once at accept and held until grant
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= IDLE;
      cause <= 2'd0;
      size_q <= 2'd0;
      store_q <= 1'b0;
      uns_q <= 1'b0;
      off_q <= '0;
      ld_q <= '0;
      cnt <= '0;
      dmem_we_o <= 1'b0;
      dmem_addr_o <= '0;
      dmem_be_o <= '0;
      dmem_wdata_o <= '0;
    end else
      case (state)
        IDLE: if (req_valid_i) begin
          store_q <= is_store_i;
          size_q <= size_i;
          uns_q <= unsigned_i;
          off_q <= off;
          dmem_we_o <= is_store_i;
          dmem_addr_o <= {ea[XLEN-1:OFFW], {OFFW{1'b0}}};
          dmem_be_o <= be_n;
          dmem_wdata_o <= rs2_i << {off, 3'b000};
          cause <= err_next;
          ld_q <= '0;
          cnt <= '0;
          state <= err_next != 2'd0 ? DONE : REQ;
        end
        REQ: if (dmem_gnt_i) state <= store_q ? DONE : WAIT;
        WAIT: if (dmem_rvalid_i) begin
          ld_q <= ext;
          state <= DONE;
        end else if (TIMEOUT_CYCLES != 0 && cnt == CNT_LAST) begin
          cause <= 2'd3;
          state <= DONE;
        end else
          cnt <= cnt + CW'(1);
        default: state <= IDLE;
      endcase
  assign req_ready_o = state == IDLE;
  assign busy_o = !req_ready_o;
  assign dmem_req_o = state == REQ;
  assign done_o = state == DONE;
  assign err_o = done_o && cause != 2'd0;
  assign err_cause_o = done_o ? cause : 2'd0;
  assign load_data_o = done_o ? ld_q : '0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed table, random model-checked traffic, timeout, async reset and XLEN=64 checks
module tb_load_store_unit;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic req_valid, is_store, uns, gnt, rvalid, req_ready, dreq, we, done, err, busy;
  logic [1:0] size, cause;
  logic [31:0] rs1, rs2, imm, rdata, addr, wdata, ld;
  logic [3:0] be;
  logic w_valid, w_store, w_uns, w_gnt, w_rvalid, w_ready, w_dreq, w_we, w_done, w_err, w_busy;
  logic [1:0] w_size, w_cause;
  logic [63:0] w_rs1, w_rs2, w_imm, w_rdata, w_addr, w_wdata, w_ld;
  logic [7:0] w_be;
  int checks = 0, failures = 0;

  load_store_unit #(.XLEN(32), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .is_store_i(is_store), .size_i(size), .unsigned_i(uns), .rs1_i(rs1), .rs2_i(rs2), .imm_i(imm),
    .dmem_req_o(dreq), .dmem_we_o(we), .dmem_addr_o(addr), .dmem_be_o(be), .dmem_wdata_o(wdata),
    .dmem_gnt_i(gnt), .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata),
    .done_o(done), .load_data_o(ld), .err_o(err), .err_cause_o(cause), .busy_o(busy)
  );

  load_store_unit #(.XLEN(64), .TIMEOUT_CYCLES(16)) dut64 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(w_valid), .req_ready_o(w_ready),
    .is_store_i(w_store), .size_i(w_size), .unsigned_i(w_uns), .rs1_i(w_rs1), .rs2_i(w_rs2), .imm_i(w_imm),
    .dmem_req_o(w_dreq), .dmem_we_o(w_we), .dmem_addr_o(w_addr), .dmem_be_o(w_be), .dmem_wdata_o(w_wdata),
    .dmem_gnt_i(w_gnt), .dmem_rvalid_i(w_rvalid), .dmem_rdata_i(w_rdata),
    .done_o(w_done), .load_data_o(w_ld), .err_o(w_err), .err_cause_o(w_cause), .busy_o(w_busy)
  );

  typedef struct {
    bit st; logic [1:0] sz; bit un;
    logic [31:0] a, b, im;
    int gd, rd;
    logic [31:0] rdat;
    logic [1:0] ec;
    logic [31:0] eaddr;
    logic [3:0] ebe;
    logic [31:0] ewd, eld;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input bit st, input logic [1:0] sz, input bit un,
                              input logic [31:0] a, b, im, input int gd, rd, input logic [31:0] rdat,
                              input logic [1:0] ec, input logic [31:0] eaddr, input logic [3:0] ebe,
                              input logic [31:0] ewd, eld);
    vec_t v;
    v.st = st; v.sz = sz; v.un = un; v.a = a; v.b = b; v.im = im; v.gd = gd; v.rd = rd; v.rdat = rdat;
    v.ec = ec; v.eaddr = eaddr; v.ebe = ebe; v.ewd = ewd; v.eld = eld;
    return v;
  endfunction

  // Byte-level reference: which lanes are touched, where store bytes land, how load bytes assemble
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int nb, off;
    logic [31:0] ea;
    r = v;
    nb = 1 << v.sz;
    ea = v.a + v.im;
    off = int'(ea % 4);
    r.ec = 2'd0; r.eaddr = ea - 32'(off); r.ebe = 4'd0; r.ewd = 32'd0; r.eld = 32'd0;
    if (v.sz == 2'd3) begin
      r.ec = 2'd2;
      return r;
    end
    if (off % nb != 0) begin
`ifdef MISALIGN_TRAP_EN
      r.ec = 2'd1;
      return r;
`else
      off = off - off % nb;
`endif
    end
    for (int k = 0; k < nb; k++) r.ebe[off + k] = 1'b1;
    for (int j = off; j < 4; j++) r.ewd[8*j +: 8] = v.b[8*(j - off) +: 8];
    if (!v.st) begin
      for (int k = 0; k < nb; k++) r.eld[8*k +: 8] = v.rdat[8*(off + k) +: 8];
      if (!v.un && nb < 4 && v.rdat[8*(off + nb) - 1]) r.eld = r.eld | (32'hFFFF_FFFF << (8 * nb));
    end
    return r;
  endfunction

  task automatic txn(input vec_t v);
    chk("idle_ready", req_ready, 1);
    req_valid = 1'b1; is_store = v.st; size = v.sz; uns = v.un; rs1 = v.a; rs2 = v.b; imm = v.im;
    tick();
    req_valid = 1'b0; is_store = ~v.st; size = ~v.sz; uns = ~v.un; rs1 = $urandom; rs2 = $urandom; imm = $urandom;
    if (v.ec == 2'd1 || v.ec == 2'd2) begin
      chk("err_done", done, 1);
      chk("err_flag", err, 1);
      chk("err_cause", cause, v.ec);
      chk("err_noreq", dreq, 0);
      chk("err_ld", ld, 0);
    end else begin
      for (int i = 0; i <= v.gd; i++) begin
        chk("req", dreq, 1);
        chk("req_ready_low", req_ready, 0);
        chk("addr", addr, v.eaddr);
        chk("be", be, v.ebe);
        chk("we", we, v.st);
        if (v.st) chk("wdata", wdata, v.ewd);
        gnt = (i == v.gd);
        rvalid = gnt && !v.st;
        rdata = ~v.rdat;
        tick();
        gnt = 1'b0; rvalid = 1'b0;
      end
      if (!v.st) begin
        for (int j = 0; j < v.rd; j++) begin
          chk("wait_nodone", done, 0);
          chk("wait_noreq", dreq, 0);
          tick();
        end
        rvalid = 1'b1; rdata = v.rdat;
        tick();
        rvalid = 1'b0; rdata = $urandom;
      end
      chk("done", done, 1);
      chk("ok_err", err, 0);
      chk("ok_cause", cause, 0);
      chk("load_data", ld, v.eld);
    end
    tick();
    chk("after_done", done, 0);
    chk("back_idle", req_ready, 1);
  endtask

  initial begin
    vec_t v;
    req_valid = 0; is_store = 0; size = 0; uns = 0; rs1 = 0; rs2 = 0; imm = 0; gnt = 0; rvalid = 0; rdata = 0;
    w_valid = 0; w_store = 0; w_size = 0; w_uns = 0; w_rs1 = 0; w_rs2 = 0; w_imm = 0; w_gnt = 0; w_rvalid = 0; w_rdata = 0;
    vt[0] = mk(1, 0, 0, 32'h1000, 32'hAB, 32'd3, 0, 0, 0, 0, 32'h1000, 4'b1000, 32'hAB00_0000, 0);
    vt[1] = mk(0, 1, 0, 32'h1000, 0, 32'd2, 0, 2, 32'h8001_1234, 0, 32'h1000, 4'b1100, 0, 32'hFFFF_8001);
    vt[2] = mk(0, 1, 1, 32'h1000, 0, 32'd2, 1, 0, 32'h8001_1234, 0, 32'h1000, 4'b1100, 0, 32'h0000_8001);
`ifdef MISALIGN_TRAP_EN
    vt[3] = mk(0, 2, 0, 32'h1000, 0, 32'd1, 0, 0, 32'hCAFE_BABE, 1, 0, 0, 0, 0);
    vt[7] = mk(1, 1, 0, 32'h3000, 32'h1234, 32'd3, 0, 0, 0, 1, 0, 0, 0, 0);
`else
    vt[3] = mk(0, 2, 0, 32'h1000, 0, 32'd1, 0, 1, 32'hCAFE_BABE, 0, 32'h1000, 4'b1111, 0, 32'hCAFE_BABE);
    vt[7] = mk(1, 1, 0, 32'h3000, 32'h1234, 32'd3, 1, 0, 0, 0, 32'h3000, 4'b1100, 32'h1234_0000, 0);
`endif
    vt[4] = mk(1, 2, 0, 32'h2000, 32'hDEAD_BEEF, 32'd4, 3, 0, 0, 0, 32'h2004, 4'b1111, 32'hDEAD_BEEF, 0);
    vt[5] = mk(0, 3, 0, 32'h4000, 0, 32'd0, 0, 0, 32'h1234_5678, 2, 0, 0, 0, 0);
    vt[6] = mk(0, 0, 0, 32'h10, 0, 32'hFFFF_FFF1, 0, 3, 32'h0000_8000, 0, 32'h0, 4'b0010, 0, 32'hFFFF_FF80);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_req", dreq, 0);
    chk("rst_done", done, 0);
    chk("rst_err", {err, cause}, 0);
    chk("rst_ld", ld, 0);
    chk("rst_addr_be", {addr, be}, 0);
    chk("rst_ready64", w_ready, 1);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) txn(vt[i]);
    for (int n = 0; n < 300; n++) begin
      v.st = 1'($urandom); v.sz = 2'($urandom_range(0, 3)); v.un = 1'($urandom);
      v.a = $urandom; v.b = $urandom; v.im = (n % 2 == 0) ? 32'($urandom_range(0, 64)) : $urandom;
      v.gd = $urandom_range(0, 3); v.rd = $urandom_range(0, 4); v.rdat = $urandom;
      txn(model(v));
    end
    // Load that never sees rvalid: sixteen WAIT cycles then a timeout completion
    req_valid = 1'b1; is_store = 1'b0; size = 2'd2; uns = 1'b0; rs1 = 32'h100; imm = 32'd0;
    tick();
    req_valid = 1'b0;
    chk("to_req", dreq, 1);
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("to_wait_nodone", done, 0);
      chk("to_wait_busy", busy, 1);
      tick();
    end
    chk("to_done", done, 1);
    chk("to_err", err, 1);
    chk("to_cause", cause, 3);
    chk("to_ld", ld, 0);
    rvalid = 1'b1; rdata = 32'h5555_AAAA;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("late_rvalid_nodone", done, 0);
      chk("late_rvalid_idle", req_ready, 1);
    end
    rvalid = 1'b0;
    // Reset asserted between clock edges while waiting for read data
    req_valid = 1'b1; is_store = 1'b0; size = 2'd2; rs1 = 32'h200; imm = 32'd0;
    tick();
    req_valid = 1'b0; gnt = 1'b1;
    tick();
    gnt = 1'b0;
    tick();
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_req", dreq, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_ready", req_ready, 1);
    tick();
    rst = 1'b0;
    tick();
    // Wide datapath: aligned double load and a signed word from the upper half
    for (int k = 0; k < 2; k++) begin
      chk("w_idle", w_ready, 1);
      w_valid = 1'b1; w_store = 1'b0; w_uns = 1'b0; w_size = k == 0 ? 2'd3 : 2'd2;
      w_rs1 = 64'h2000; w_imm = k == 0 ? 64'h8 : 64'hC;
      tick();
      w_valid = 1'b0;
      chk("w_req", w_dreq, 1);
      chk("w_addr", w_addr, 64'h2008);
      chk("w_be", w_be, k == 0 ? 8'hFF : 8'hF0);
      w_gnt = 1'b1;
      tick();
      w_gnt = 1'b0; w_rvalid = 1'b1;
      w_rdata = k == 0 ? 64'h0123_4567_89AB_CDEF : 64'h8000_0000_1111_1111;
      tick();
      w_rvalid = 1'b0;
      chk("w_done", w_done, 1);
      chk("w_err", w_err, 0);
      chk("w_ld", w_ld, k == 0 ? 64'h0123_4567_89AB_CDEF : 64'hFFFF_FFFF_8000_0000);
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Parametrised successor to the combinational memory address/data stage.
- Registers a load/store request from the execute pipeline and computes the effective address `rs1 + imm`.
- Drives a req/gnt/rvalid data-memory handshake with byte enables and lane-aligned write data.
- Returns sign/zero-extended load data, or an error, with a one-cycle `done_o` pulse.
- Supports XLEN 32 or 64, stalls on memory back-pressure, and bounds response wait with a timeout counter.

Parameters:
- XLEN, 32, datapath/address width; legal values 32 or 64.
- TIMEOUT_CYCLES, 16, maximum WAIT cycles before a bus error; 0 disables the timeout.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- req_valid_i  in  1  request valid from pipeline.
- req_ready_o  out  1  unit idle, request accepted this cycle if valid.
- is_store_i  in  1  1 = store, 0 = load.
- size_i  in  2  0 byte, 1 half, 2 word, 3 double.
- unsigned_i  in  1  load zero-extend when 1.
- rs1_i  in  XLEN  base register.
- rs2_i  in  XLEN  store data.
- imm_i  in  XLEN  sign-extended offset.
- dmem_req_o  out  1  memory request.
- dmem_we_o  out  1  write enable.
- dmem_addr_o  out  XLEN  word/dword-aligned address; low log2(XLEN/8) bits are 0.
- dmem_be_o  out  XLEN/8  byte enables.
- dmem_wdata_o  out  XLEN  lane-shifted store data.
- dmem_gnt_i  in  1  request accepted by memory.
- dmem_rvalid_i  in  1  read data valid.
- dmem_rdata_i  in  XLEN  read data.
- done_o  out  1  one-cycle completion pulse.
- load_data_o  out  XLEN  extended load result, valid with done_o.
- err_o  out  1  with done_o: access failed.
- err_cause_o  out  2  0 none, 1 misaligned, 2 illegal size, 3 timeout.
- busy_o  out  1  not IDLE.

Behaviour:
- Reset (asynchronous, immediate): state IDLE; all outputs 0 except `req_ready_o` = 1. Any in-flight access is abandoned and `dmem_req_o` drops at once.
- Shared definitions:
  - OFFW = log2(XLEN/8).
  - `ea` = `rs1_i + imm_i`, modulo 2^XLEN, captured on accept.
  - `off` = `ea[OFFW-1:0]`; nbytes = 1 << `size_i`.
- FSM states: IDLE, REQ, WAIT, DONE.
  - `req_ready_o` = (state == IDLE).
  - `busy_o` = !`req_ready_o`.
- IDLE:
  - On `req_valid_i`, latch all request fields and `ea`.
  - Next state is DONE with error if any of the following holds (no memory request is issued):
    - `size_i` = 3 with XLEN = 32 (cause 2);
    - misaligned per Optional Feature (cause 1).
  - Otherwise next state is REQ.
- REQ:
  - `dmem_req_o` = 1.
  - `dmem_addr_o`, `dmem_be_o`, `dmem_wdata_o` and `dmem_we_o` are registered and held stable until grant.
  - `dmem_be_o` = ((1 << nbytes) - 1) << `off`.
  - `dmem_wdata_o` = `rs2_i` << (8 * `off`).
  - On `dmem_gnt_i`: store goes to DONE, load goes to WAIT.
  - `dmem_req_o` deasserts the cycle after grant.
- WAIT:
  - `dmem_rvalid_i` is sampled only in this state; rvalid coinciding with gnt in REQ is ignored.
  - On rvalid: `load_data_o` = (`dmem_rdata_i` >> 8*`off`), truncated to nbytes and sign- or zero-extended per `unsigned_i`. Go to DONE.
  - A cycle counter starts at 0 on entry. If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES - 1 without rvalid, go to DONE with cause 3. A late rvalid is ignored.
- DONE: `done_o` = 1 for exactly one cycle, then IDLE. `err_o`/`err_cause_o` are valid only in this cycle, else 0.
- `load_data_o` is 0 for stores and errors.
- Latency (no stall):
  - store: accept → `done_o` 2 cycles later;
  - load: rvalid cycle + 1.
- A new request can be accepted the cycle after `done_o`.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined: an access with `off` % nbytes != 0 completes as an error with cause 1. No `dmem_req_o` is issued; `done_o` asserts the cycle after accept.
- Undefined:
  - Never an error.
  - `off` is forced down to a multiple of nbytes (low log2(nbytes) bits cleared) before computing `be`, `wdata` and the load shift.
  - The access proceeds normally.
  - `err_cause_o` never equals 1.

Test Plan:
- Store byte, XLEN=32, `rs1_i`=0x1000, `imm_i`=3, `rs2_i`=0xAB, gnt in the first REQ cycle:
  - `dmem_addr_o`=0x1000, `dmem_be_o`=4'b1000, `dmem_wdata_o`=0xAB000000, `dmem_we_o`=1;
  - `done_o` 2 cycles after accept, `err_o`=0.
- Signed half load at `ea` 0x1002, `dmem_rdata_i`=0x8001_1234 → `dmem_be_o`=4'b1100, `load_data_o`=0xFFFF8001. Same access with `unsigned_i`=1 → 0x00008001.
- Word load at 0x1001:
  - with MISALIGN_TRAP_EN: no `dmem_req_o`; `done_o` next cycle with `err_o`=1, `err_cause_o`=1;
  - without it: `dmem_addr_o`=0x1000, `dmem_be_o`=4'b1111, normal completion.
- Gnt withheld 3 cycles on a store: `dmem_req_o`, address, be and wdata constant for all 4 REQ cycles; `req_ready_o`=0 throughout; single `done_o` after grant.
- Load with TIMEOUT_CYCLES=16 and rvalid never asserted: `done_o` with `err_cause_o`=3 after 16 WAIT cycles; rvalid injected afterwards produces no second `done_o`.
- Assert `rst_i` in mid-WAIT: `dmem_req_o`/`busy_o`/`done_o`=0 immediately, without waiting for a clock edge; after release, XLEN=64 double load at 0x2008 → `dmem_be_o`=8'hFF, `load_data_o`=`dmem_rdata_i`.
